mac_serial_engine: RTL and testbench

- Bit-serial multiply-accumulate engine; next generation of the FPGA MAC used with the host bit-bang command tool.
- Single clock domain with clock enables only, so there is no gated clock and no cmd-derived clock.
- Operands and the accumulator are moved through a 1-bit serial interface strobed by `bit_en`.
- Multiplication is an iterative shift-add sequence with busy/done handshake.
- Signed mode is selectable; overflow is detected; saturation is an optional build feature.

---
 rtl/mac_serial_engine.sv | 157 +++++++++++++++
 tb/tb_mac_serial_engine.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_serial_engine.sv
// Bit-serial multiply-accumulate engine with a shift-add multiplier.
// Define MAC_SATURATE_EN to clamp the accumulator on overflow.
module mac_serial_engine #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 32,
    parameter int SIGNED    = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] cmd,
    input  logic       bit_en,
    input  logic       din,
    output logic       dout,
    output logic       busy,
    output logic       done,
    output logic       ovf,
    output logic       cmd_err
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        ACC
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [WIDTH-1:0]     mplier;
    logic [PW-1:0]        mcand;
    logic [PW-1:0]        prod;
    logic                 neg;
    logic [CW-1:0]        cnt;
    logic [ACC_WIDTH-1:0] acc;

    logic [PW-1:0]        prod_s;
    logic                 ext;
    logic [ACC_WIDTH-1:0] pext;
    logic [ACC_WIDTH:0]   sum;
    logic                 ovf_now;
    logic [ACC_WIDTH-1:0] acc_next;

    assign dout = acc[ACC_WIDTH-1];

    // Magnitude of an operand; the most negative value maps to 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        if (SIGNED != 0 && x[WIDTH-1])
            return -x;
        return x;
    endfunction

    always_comb begin
        prod_s = neg ? -prod : prod;
        ext    = (SIGNED != 0) & prod_s[PW-1];
        pext   = {ACC_WIDTH{ext}};
        pext[PW-1:0] = prod_s;
        sum    = {1'b0, acc} + {1'b0, pext};
        if (SIGNED != 0)
            ovf_now = (acc[ACC_WIDTH-1] == pext[ACC_WIDTH-1]) &&
                      (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
        else
            ovf_now = sum[ACC_WIDTH];
`ifdef MAC_SATURATE_EN
        if (!ovf_now)
            acc_next = sum[ACC_WIDTH-1:0];
        else if (SIGNED == 0)
            acc_next = '1;
        else if (acc[ACC_WIDTH-1])
            acc_next = {1'b1, {(ACC_WIDTH-1){1'b0}}};
        else
            acc_next = {1'b0, {(ACC_WIDTH-1){1'b1}}};
`else
        acc_next = sum[ACC_WIDTH-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            a       <= '0;
            b       <= '0;
            mplier  <= '0;
            mcand   <= '0;
            prod    <= '0;
            neg     <= 1'b0;
            cnt     <= '0;
            acc     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
            cmd_err <= 1'b0;
        end else begin
            done <= 1'b0;
            if (bit_en && state != IDLE)
                cmd_err <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (bit_en) begin
                        unique case (cmd)
                            2'b00: begin
                                acc     <= '0;
                                a       <= '0;
                                b       <= '0;
                                ovf     <= 1'b0;
                                cmd_err <= 1'b0;
                            end
                            2'b01: begin
                                b <= {b[WIDTH-2:0], a[WIDTH-1]};
                                a <= {a[WIDTH-2:0], din};
                            end
                            2'b10: begin
                                mcand  <= PW'(mag(a));
                                mplier <= mag(b);
                                prod   <= '0;
                                neg    <= (SIGNED != 0) &&
                                          (a[WIDTH-1] ^ b[WIDTH-1]);
                                cnt    <= CW'(WIDTH);
                                busy   <= 1'b1;
                                state  <= MUL;
                            end
                            2'b11: begin
                                acc <= {acc[ACC_WIDTH-2:0], acc[ACC_WIDTH-1]};
                            end
                        endcase
                    end
                end
                MUL: begin
                    if (mplier[0])
                        prod <= prod + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CW'(1);
                    // done is registered so it is high for the whole ACC cycle
                    if (cnt == CW'(1)) begin
                        state <= ACC;
                        done  <= 1'b1;
                    end
                end
                ACC: begin
                    acc   <= acc_next;
                    if (ovf_now)
                        ovf <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_serial_engine.sv
// Bench for mac_serial_engine: unsigned and signed instances share stimulus,
// a reference model feeds a scoreboard checked on each done pulse.
module tb_mac_serial_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] cmd;
    logic       bit_en;
    logic       din;
    logic       dout_u, busy_u, done_u, ovf_u, err_u;
    logic       dout_s, busy_s, done_s, ovf_s, err_s;

    always #5 clk = ~clk;

    mac_serial_engine #(.WIDTH(16), .ACC_WIDTH(32), .SIGNED(0)) u_dut (
        .clk(clk), .reset(reset), .cmd(cmd), .bit_en(bit_en), .din(din),
        .dout(dout_u), .busy(busy_u), .done(done_u), .ovf(ovf_u),
        .cmd_err(err_u)
    );

    mac_serial_engine #(.WIDTH(16), .ACC_WIDTH(32), .SIGNED(1)) s_dut (
        .clk(clk), .reset(reset), .cmd(cmd), .bit_en(bit_en), .din(din),
        .dout(dout_s), .busy(busy_s), .done(done_s), .ovf(ovf_s),
        .cmd_err(err_s)
    );

    typedef struct {
        logic [31:0] acc_u;
        logic [31:0] acc_s;
        logic        ovf_u;
        logic        ovf_s;
    } exp_t;

    typedef struct {
        bit          clr;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] eu;
        logic [31:0] es;
        logic        ou;
        logic        os;
    } row_t;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    int          nerr = 0;
    int          nchk = 0;
    exp_t        sbq[$];
    logic [15:0] ma, mb;
    logic [31:0] m_acc_u, m_acc_s;
    logic        m_ovf_u, m_ovf_s;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [1:0] c, input logic d);
        cmd    = c;
        din    = d;
        bit_en = 1'b1;
        step();
        bit_en = 1'b0;
    endtask

    task automatic model_reset();
        ma      = '0;
        mb      = '0;
        m_acc_u = '0;
        m_acc_s = '0;
        m_ovf_u = 1'b0;
        m_ovf_s = 1'b0;
    endtask

    task automatic do_clear();
        strobe(2'b00, 1'b0);
        model_reset();
    endtask

    task automatic load(input logic [15:0] av, input logic [15:0] bv);
        for (int i = 15; i >= 0; i--) strobe(2'b01, bv[i]);
        for (int i = 15; i >= 0; i--) strobe(2'b01, av[i]);
        ma = av;
        mb = bv;
    endtask

    task automatic model_mac();
        exp_t   e;
        longint tu, ts;
        tu = {32'd0, m_acc_u} + longint'({16'd0, ma}) * longint'({16'd0, mb});
        if (tu > 64'sh0_FFFF_FFFF) begin
            m_ovf_u = 1'b1;
`ifdef MAC_SATURATE_EN
            m_acc_u = 32'hFFFF_FFFF;
`else
            m_acc_u = tu[31:0];
`endif
        end else begin
            m_acc_u = tu[31:0];
        end
        ts = longint'($signed(m_acc_s)) +
             longint'($signed(ma)) * longint'($signed(mb));
        if (ts > SMAX || ts < SMIN) begin
            m_ovf_s = 1'b1;
`ifdef MAC_SATURATE_EN
            m_acc_s = (ts > SMAX) ? 32'h7FFF_FFFF : 32'h8000_0000;
`else
            m_acc_s = ts[31:0];
`endif
        end else begin
            m_acc_s = ts[31:0];
        end
        e.acc_u = m_acc_u;
        e.acc_s = m_acc_s;
        e.ovf_u = m_ovf_u;
        e.ovf_s = m_ovf_s;
        sbq.push_back(e);
    endtask

    task automatic read_acc(output logic [31:0] u, output logic [31:0] s);
        for (int i = 31; i >= 0; i--) begin
            u[i] = dout_u;
            s[i] = dout_s;
            strobe(2'b11, 1'b0);
        end
    endtask

    // Issue a MAC, optionally poking strobes into the busy window.
    task automatic run_mac(input bit perturb);
        int n  = 0;
        int du = -1;
        int ds = -1;
        model_mac();
        strobe(2'b10, 1'b0);
        while (busy_u && n < 40) begin
            if (done_u) du = n;
            if (done_s) ds = n;
            if (perturb && n == 2) begin
                cmd = 2'b01; din = 1'b1; bit_en = 1'b1;
            end else if (perturb && n == 3) begin
                cmd = 2'b11; din = 1'b0; bit_en = 1'b1;
            end else begin
                bit_en = 1'b0;
            end
            step();
            n++;
        end
        bit_en = 1'b0;
        check("busy_len", n, 17);
        check("done_at_u", du, 16);
        check("done_at_s", ds, 16);
        check("done_low", {done_u, done_s}, 2'b00);
    endtask

    task automatic check_sb(input string tag);
        exp_t        e;
        logic [31:0] u, s;
        nchk++;
        if (sbq.size() == 0) begin
            nerr++;
            $display("FAIL %s_sb_empty: got 0 entries, want 1", tag);
            return;
        end
        e = sbq.pop_front();
        read_acc(u, s);
        check({tag, "_acc_u"}, u, e.acc_u);
        check({tag, "_acc_s"}, s, e.acc_s);
        check({tag, "_ovf_u"}, ovf_u, e.ovf_u);
        check({tag, "_ovf_s"}, ovf_s, e.ovf_s);
    endtask

    row_t rows[9];

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] u, s;
        bit          saw;

        rows[0] = '{1'b1, 16'h0005, 16'h0003, 32'h0000_000F, 32'h0000_000F, 1'b0, 1'b0};
        rows[1] = '{1'b1, 16'hFFFE, 16'h0003, 32'h0002_FFFA, 32'hFFFF_FFFA, 1'b0, 1'b0};
        rows[2] = '{1'b1, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 32'h0000_0001, 1'b0, 1'b0};
`ifdef MAC_SATURATE_EN
        rows[3] = '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b0};
`else
        rows[3] = '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFC_0002, 32'h0000_0002, 1'b1, 1'b0};
`endif
        rows[4] = '{1'b1, 16'h8000, 16'h8000, 32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0};
`ifdef MAC_SATURATE_EN
        rows[5] = '{1'b0, 16'h8000, 16'h8000, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1};
`else
        rows[5] = '{1'b0, 16'h8000, 16'h8000, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1};
`endif
        rows[6] = '{1'b1, 16'h7FFF, 16'h8000, 32'h3FFF_8000, 32'hC000_8000, 1'b0, 1'b0};
        rows[7] = '{1'b0, 16'h8000, 16'h8000, 32'h7FFF_8000, 32'h0000_8000, 1'b0, 1'b0};
        rows[8] = '{1'b1, 16'h0000, 16'h1234, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};

        reset  = 1'b0;
        bit_en = 1'b0;
        cmd    = 2'b00;
        din    = 1'b0;
        step();
        step();
        reset = 1'b1;
        model_reset();
        check("rst_busy", {busy_u, busy_s}, 2'b00);
        check("rst_done", {done_u, done_s}, 2'b00);
        check("rst_ovf", {ovf_u, ovf_s}, 2'b00);
        check("rst_err", {err_u, err_s}, 2'b00);
        read_acc(u, s);
        check("rst_acc_u", u, 32'h0);
        check("rst_acc_s", s, 32'h0);

        for (int r = 0; r < 9; r++) begin
            if (rows[r].clr) do_clear();
            load(rows[r].a, rows[r].b);
            run_mac(1'b0);
            check_sb($sformatf("row%0d", r));
            read_acc(u, s);
            check($sformatf("row%0d_tab_u", r), u, rows[r].eu);
            check($sformatf("row%0d_tab_s", r), s, rows[r].es);
            check($sformatf("row%0d_tab_ovf_u", r), ovf_u, rows[r].ou);
            check($sformatf("row%0d_tab_ovf_s", r), ovf_s, rows[r].os);
            check($sformatf("row%0d_err", r), {err_u, err_s}, 2'b00);
        end

        do_clear();
        load(16'h0005, 16'h0003);
        run_mac(1'b1);
        check("busy_strobe_err", {err_u, err_s}, 2'b11);
        check_sb("perturbed");
        run_mac(1'b0);
        check_sb("remac");
        do_clear();
        check("clear_err", {err_u, err_s}, 2'b00);

        load(16'h0007, 16'h0009);
        strobe(2'b10, 1'b0);
        repeat (4) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        model_reset();
        check("midrst_busy", {busy_u, busy_s}, 2'b00);
        saw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done_u || done_s) saw = 1'b1;
            step();
        end
        check("midrst_no_done", saw, 1'b0);
        read_acc(u, s);
        check("midrst_acc_u", u, 32'h0);
        check("midrst_acc_s", s, 32'h0);
        load(16'h0007, 16'h0009);
        run_mac(1'b0);
        check_sb("after_rst");

        do_clear();
        load(16'h0005, 16'h0003);
        run_mac(1'b0);
        check_sb("chain0");
        load(16'h0009, 16'h0007);
        run_mac(1'b0);
        check_sb("chain1");
        load(16'h0010, 16'h1234);
        run_mac(1'b0);
        check_sb("chain2");
        read_acc(u, s);
        check("chain_u", u, 32'h0001_238E);
        check("chain_s", s, 32'h0001_238E);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
